postadder_mc: RTL and testbench

POSTADDER_MC -- requirements
Module: postadder_mc

---
 rtl/postadder_mc.sv | 191 +++++++++++++++++++
 tb/tb_postadder_mc.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/postadder_mc.sv
// postadder_mc: multi-channel, multi-thread post-adder with per-slot storage.
//
// Each of the N_CH channels owns N_THREADS*DEPTH slots of W bits. One accepted
// operation runs a 3-bit opcode in every channel at once, on slot
// [tid][addr_c]. The result of channel outsel is registered onto dout.
// A clr_all pulse starts a sweep that zeroes one (tid, addr) index per cycle
// in all channels. While the sweep runs, no operations are accepted.
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   in_valid / in_ready    operation handshake
//   din                    operand (W bits)
//   tid                    thread context
//   op                     per-channel opcode, channel c at [3c+2:3c]
//   addr                   per-channel slot index, channel c at [AW*c +: AW]
//   outsel                 channel driven on dout (>= N_CH gives 0)
//   clr_all                starts the clear sweep
//   dout_valid / dout      registered result, one cycle after acceptance
//   busy                   clear sweep in progress
//   ovf (optional)         sticky per-channel carry/borrow flags
//
// Build option: define POSTADDER_MC_OVF_FLAG_EN to add the ovf port and its
// overflow tracking.

module postadder_mc_alu #(
    parameter int W = 256,
    parameter logic [W-1:0] P = '0
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] s,
    input  logic [W-1:0] din,
    output logic [W-1:0] res
`ifdef POSTADDER_MC_OVF_FLAG_EN
    , output logic       ov
`endif
);
    // With overflow tracking, one extra bit catches the carry/borrow out of
    // bit W-1. A W+1-bit subtraction sets that bit exactly when it borrows.
`ifdef POSTADDER_MC_OVF_FLAG_EN
    localparam int RW = W + 1;
`else
    localparam int RW = W;
`endif

    logic [RW-1:0] ws, wd, wp, r;

    assign ws = RW'(s);
    assign wd = RW'(din);
    assign wp = RW'(P);

    always_comb begin
        r = ws;
        case (op)
            3'b000: r = ws;
            3'b001: r = wd;
            3'b010: r = ws + wd;
            3'b011: r = ws - wd;
            3'b100: r = wd - ws;
            3'b101: r = ws + wp;
            3'b110: r = '0 - wd;
            3'b111: r = '0;
            default: r = ws;
        endcase
    end

    assign res = r[W-1:0];

`ifdef POSTADDER_MC_OVF_FLAG_EN
    always_comb begin
        ov = 1'b0;
        if (op inside {3'b010, 3'b011, 3'b100, 3'b101, 3'b110})
            ov = r[W];
    end
`endif
endmodule

module postadder_mc #(
    parameter int N_CH      = 3,
    parameter int N_THREADS = 4,
    parameter int DEPTH     = 4,
    parameter int W         = 256,
    parameter logic [W-1:0] P = '0,
    localparam int TW = (N_THREADS > 1) ? $clog2(N_THREADS) : 1,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      din,
    input  logic [TW-1:0]     tid,
    input  logic [N_CH*3-1:0] op,
    input  logic [N_CH*AW-1:0] addr,
    input  logic [OW-1:0]     outsel,
    input  logic              clr_all,
    output logic              dout_valid,
    output logic [W-1:0]      dout,
    output logic              busy
`ifdef POSTADDER_MC_OVF_FLAG_EN
    , output logic [N_CH-1:0] ovf
`endif
);
    localparam int TOT = N_THREADS * DEPTH;
    localparam int IW  = (TOT > 1) ? $clog2(TOT) : 1;

    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state, state_nxt;

    logic [IW-1:0] cnt;
    logic          acc, clr_last;
    logic [W-1:0]  sel;

    logic [W-1:0]  mem [N_CH][TOT];
    logic [N_CH-1:0][W-1:0]  cur, nxt;
    logic [N_CH-1:0][IW-1:0] idx;
`ifdef POSTADDER_MC_OVF_FLAG_EN
    logic [N_CH-1:0] ovc;
`endif

    assign in_ready = (state == IDLE);
    assign busy     = (state == CLEAR);
    assign acc      = in_valid && in_ready;
    assign clr_last = busy && (cnt == IW'(TOT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_all)  state_nxt = CLEAR;
            CLEAR:   if (clr_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Slots are flops written at the edge, so a read in the cycle after a
    // write already sees the new value. No forwarding path is needed.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [IW-1:0] ti, ai;
        assign ti     = (N_THREADS > 1) ? IW'(tid) : '0;
        assign ai     = (DEPTH > 1) ? IW'(addr[c*AW +: AW]) : '0;
        assign idx[c] = ti * IW'(DEPTH) + ai;
        assign cur[c] = mem[c][idx[c]];

        postadder_mc_alu #(.W(W), .P(P)) u_alu (
            .op  (op[3*c +: 3]),
            .s   (cur[c]),
            .din (din),
            .res (nxt[c])
`ifdef POSTADDER_MC_OVF_FLAG_EN
            , .ov(ovc[c])
`endif
        );
    end

    always_comb begin
        sel = '0;
        for (int c = 0; c < N_CH; c++)
            if (outsel == OW'(c)) sel = nxt[c];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            for (int c = 0; c < N_CH; c++)
                for (int i = 0; i < TOT; i++)
                    mem[c][i] <= '0;
        end else begin
            state      <= state_nxt;
            dout_valid <= acc;
            if (busy) cnt <= clr_last ? '0 : cnt + IW'(1);
            if (acc) begin
                dout <= sel;
                for (int c = 0; c < N_CH; c++)
                    mem[c][idx[c]] <= nxt[c];
            end
            if (busy)
                for (int c = 0; c < N_CH; c++)
                    mem[c][cnt] <= '0;
        end
    end

`ifdef POSTADDER_MC_OVF_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst || clr_last) ovf <= '0;
        else if (acc)        ovf <= ovf | ovc;
    end
`endif
endmodule

// File: tb/tb_postadder_mc.sv
module tb_postadder_mc;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, clr_all, dout_valid, busy;
    logic [15:0] din, dout;
    logic [1:0]  tid, outsel;
    logic [8:0]  op;
    logic [5:0]  addr;
`ifdef POSTADDER_MC_OVF_FLAG_EN
    logic [2:0]  ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model: slot contents indexed [channel][tid*4 + addr].
    logic [15:0] ms [3][16];
    int          m_left;
    logic        m_dv;
    logic [15:0] m_dout;
    logic [2:0]  m_ovf;
    bit          chk_dout;

    postadder_mc #(.N_CH(3), .N_THREADS(4), .DEPTH(4), .W(16), .P(16'h00FF)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .din(din), .tid(tid), .op(op), .addr(addr), .outsel(outsel),
        .clr_all(clr_all), .dout_valid(dout_valid), .dout(dout), .busy(busy)
`ifdef POSTADDER_MC_OVF_FLAG_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic zero_model();
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < 16; i++)
                ms[c][i] = 16'h0;
    endtask

    // Drive one cycle, advance the model, then check after the edge.
    task automatic cyc(input bit v, input logic [1:0] t, input logic [8:0] o,
                       input logic [5:0] a, input logic [15:0] d,
                       input logic [1:0] os, input bit cl, input bit r);
        logic [15:0] s, n;
        logic [15:0] res [3];
        int ix;
        in_valid = v; tid = t; op = o; addr = a; din = d;
        outsel = os; clr_all = cl; rst = r;
        chk_dout = 0;
        if (r) begin
            zero_model();
            m_left = 0; m_dv = 0; m_dout = 0; m_ovf = 0; chk_dout = 1;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                zero_model();
                m_ovf = 0;
            end
            m_dv = 0;
        end else begin
            if (v) begin
                for (int c = 0; c < 3; c++) begin
                    ix = int'(t) * 4 + int'(a[2*c +: 2]);
                    s  = ms[c][ix];
                    n  = s;
                    case (o[3*c +: 3])
                        3'd0: n = s;
                        3'd1: n = d;
                        3'd2: begin n = s + d;       if (int'(s) + int'(d) > 65535) m_ovf[c] = 1'b1; end
                        3'd3: begin n = s - d;       if (d > s) m_ovf[c] = 1'b1; end
                        3'd4: begin n = d - s;       if (s > d) m_ovf[c] = 1'b1; end
                        3'd5: begin n = s + 16'h00FF; if (int'(s) + 255 > 65535) m_ovf[c] = 1'b1; end
                        3'd6: begin n = 16'h0 - d;   if (d != 0) m_ovf[c] = 1'b1; end
                        default: n = 16'h0;
                    endcase
                    ms[c][ix] = n;
                    res[c]    = n;
                end
                m_dout   = (os < 3) ? res[os] : 16'h0;
                m_dv     = 1;
                chk_dout = 1;
            end else begin
                m_dv = 0;
            end
            if (cl) m_left = 16;
        end
        @(posedge clk);
        #1;
        chk("dout_valid", 32'(dout_valid), 32'(m_dv));
        chk("busy", 32'(busy), 32'(m_left > 0));
        chk("in_ready", 32'(in_ready), 32'(m_left == 0));
        if (chk_dout) chk("dout", 32'(dout), 32'(m_dout));
`ifdef POSTADDER_MC_OVF_FLAG_EN
        chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
    endtask

    task automatic rnd_cyc(input int clr_pct);
        cyc($urandom_range(0, 3) != 0, 2'($urandom), 9'($urandom), 6'($urandom),
            16'($urandom), 2'($urandom_range(0, 3)),
            $urandom_range(0, 99) < clr_pct, 1'b0);
    endtask

    task automatic read_all();
        for (int t = 0; t < 4; t++)
            for (int a = 0; a < 4; a++)
                for (int c = 0; c < 3; c++)
                    cyc(1, 2'(t), 9'h0, {2'(a), 2'(a), 2'(a)}, 16'($urandom), 2'(c), 0, 0);
    endtask

    initial begin
        zero_model();
        m_left = 0; m_dv = 0; m_dout = 0; m_ovf = 0;
        in_valid = 0; tid = 0; op = 0; addr = 0; din = 0;
        outsel = 0; clr_all = 0; rst = 1;

        // Reset state
        cyc(1, 2'd0, 9'o111, 6'h0, 16'h5555, 2'd0, 0, 1);
        cyc(0, 2'd0, 9'h0, 6'h0, 16'h0, 2'd0, 0, 1);

        // LOAD then ADD on ch0
        cyc(1, 2'd0, 9'b000_000_001, 6'h0, 16'h1234, 2'd0, 0, 0);
        cyc(1, 2'd0, 9'b000_000_010, 6'h0, 16'h0001, 2'd0, 0, 0);

        // RSUB borrow on ch1, flag must stay set
        cyc(1, 2'd0, 9'b000_001_000, 6'b00_01_00, 16'h0003, 2'd1, 0, 0);
        cyc(1, 2'd0, 9'b000_100_000, 6'b00_01_00, 16'h0001, 2'd1, 0, 0);
        cyc(1, 2'd0, 9'h0, 6'b00_01_00, 16'h0000, 2'd1, 0, 0);
        cyc(0, 2'd0, 9'h0, 6'h0, 16'h0000, 2'd1, 0, 0);

        // Thread isolation
        cyc(1, 2'd0, 9'b000_000_001, 6'h2, 16'h000A, 2'd0, 0, 0);
        cyc(1, 2'd1, 9'b000_000_001, 6'h2, 16'h000B, 2'd0, 0, 0);
        cyc(1, 2'd0, 9'h0, 6'h2, 16'h0000, 2'd0, 0, 0);
        cyc(1, 2'd1, 9'h0, 6'h2, 16'h0000, 2'd0, 0, 0);

        // ADDP and out-of-range outsel
        cyc(1, 2'd2, 9'b001_000_000, 6'b11_00_00, 16'h0001, 2'd2, 0, 0);
        cyc(1, 2'd2, 9'b101_000_000, 6'b11_00_00, 16'h0000, 2'd2, 0, 0);
        cyc(1, 2'd2, 9'b001_001_001, 6'b11_00_00, 16'h7777, 2'd3, 0, 0);

        // Random operations
        for (int i = 0; i < 300; i++) rnd_cyc(0);

        // Full clear: 16 busy cycles with in_valid held high, then all zero
        cyc(0, 2'd0, 9'h0, 6'h0, 16'h0, 2'd0, 1, 0);
        for (int i = 0; i < 16; i++)
            cyc(1, 2'($urandom), 9'($urandom), 6'($urandom), 16'($urandom), 2'd0, 1, 0);
        read_all();

        // Random with clears, including op+clr together and clr while busy
        for (int i = 0; i < 300; i++) rnd_cyc(4);
        for (int i = 0; i < 20; i++) cyc(0, 2'd0, 9'h0, 6'h0, 16'h0, 2'd0, 0, 0);
        cyc(1, 2'd3, 9'b010_010_010, 6'h3F, 16'hFFFF, 2'd1, 1, 0);
        for (int i = 0; i < 16; i++) cyc(0, 2'd0, 9'h0, 6'h0, 16'h0, 2'd0, 0, 0);

        // Reset on the fifth clear cycle
        for (int i = 0; i < 60; i++) rnd_cyc(0);
        cyc(0, 2'd0, 9'h0, 6'h0, 16'h0, 2'd0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 2'd0, 9'h0, 6'h0, 16'h0, 2'd0, 0, 0);
        cyc(1, 2'd1, 9'o111, 6'h0, 16'h1111, 2'd0, 0, 1);
        read_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
